// File: rtl/input_unit.sv
// input_unit: mesh router input port (FIFO of DEPTH flits + XY route FSM); ports clk, reset, ce, i_data/i_valid in, o_en out, o_output_req to allocator, i_input_grant in, o_data to crossbar, sticky o_error, plus o_flit_count when INPUT_UNIT_STATS_EN is defined
module input_unit #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  parameter int X_LOC = 0,
  parameter int Y_LOC = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_en,
  output logic [4:0]   o_output_req,
  input  logic         i_input_grant,
  output logic [W-1:0] o_data,
  output logic         o_error
`ifdef INPUT_UNIT_STATS_EN
  ,
  output logic [15:0]  o_flit_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] XL = X_LOC[3:0];
  localparam logic [3:0] YL = Y_LOC[3:0];
  typedef enum logic {IDLE, ACTIVE} state_t;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  state_t state;
  logic [4:0] route, next_route;
  logic empty, push, drop, bad, pop;
  always_comb begin
    empty = count == '0;
    o_en = count < (AW+1)'(DEPTH);
    o_data = mem[rd_ptr];
    o_output_req = (state == ACTIVE && !empty) ? route : 5'b0;
    push = ce & i_valid & o_en;
    drop = ce & i_valid & ~o_en;
    bad = ce & (state == IDLE) & ~empty & ~o_data[W-1];
    pop = bad | (ce & i_input_grant & (|o_output_req));
    next_route = o_data[3:0] > XL ? 5'b00100 :
                 o_data[3:0] < XL ? 5'b10000 :
                 o_data[7:4] > YL ? 5'b00010 :
                 o_data[7:4] < YL ? 5'b01000 : 5'b00001;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= i_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      state <= IDLE;
      route <= '0;
      o_error <= 1'b0;
    end else if (ce) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop | bad) o_error <= 1'b1;
      if (state == IDLE && !empty && o_data[W-1]) begin
        route <= next_route;
        state <= ACTIVE;
      end else if (state == ACTIVE && pop && o_data[W-2]) state <= IDLE;
    end
  end
`ifdef INPUT_UNIT_STATS_EN
  logic [15:0] flit_count;
  always_ff @(posedge clk)
    if (reset) flit_count <= '0;
    else if (pop && flit_count != 16'hFFFF) flit_count <= flit_count + 16'd1;
  assign o_flit_count = flit_count;
`endif
endmodule

// File: tb/tb_input_unit.sv
// tb_input_unit: randomized + directed check of input_unit against a queue-based reference model
module tb_input_unit;
  localparam int W = 32;
  localparam int DEPTH = 4;
  localparam int XL = 1;
  localparam int YL = 1;
  logic clk = 1'b0;
  logic reset, ce, i_valid, i_input_grant, o_en, o_error;
  logic [W-1:0] i_data, o_data;
  logic [4:0] o_output_req;
`ifdef INPUT_UNIT_STATS_EN
  logic [15:0] o_flit_count;
`endif
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] q[$];
  bit m_act;
  logic [4:0] m_rt;
  bit m_err;
  int m_cnt;
  input_unit #(.W(W), .DEPTH(DEPTH), .X_LOC(XL), .Y_LOC(YL)) dut (
    .clk(clk), .reset(reset), .ce(ce), .i_data(i_data), .i_valid(i_valid),
    .o_en(o_en), .o_output_req(o_output_req), .i_input_grant(i_input_grant),
    .o_data(o_data), .o_error(o_error)
`ifdef INPUT_UNIT_STATS_EN
    , .o_flit_count(o_flit_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] flit(input bit h, input bit t, input int x, input int y);
    logic [3:0] xx, yy;
    xx = 4'(x);
    yy = 4'(y);
    return {h, t, {(W-10){1'b0}}, yy, xx};
  endfunction
  function automatic logic [4:0] xy_route(input logic [W-1:0] f);
    int dx, dy;
    dx = int'(f[3:0]) - XL;
    dy = int'(f[7:4]) - YL;
    if (dx > 0) return 5'b00100;
    if (dx < 0) return 5'b10000;
    if (dy > 0) return 5'b00010;
    if (dy < 0) return 5'b01000;
    return 5'b00001;
  endfunction
  function automatic logic [4:0] m_req();
    return (m_act && q.size() > 0) ? m_rt : 5'b0;
  endfunction
  task automatic cyc(input bit r, input bit c, input bit v, input logic [W-1:0] d, input bit g);
    bit full, popq;
    check("en", 32'(o_en), 32'(q.size() < DEPTH));
    check("req", 32'(o_output_req), 32'(m_req()));
    check("err", 32'(o_error), 32'(m_err));
    if (q.size() > 0) check("data", o_data, q[0]);
`ifdef INPUT_UNIT_STATS_EN
    check("cnt", 32'(o_flit_count), 32'(m_cnt));
`endif
    reset = r; ce = c; i_valid = v; i_data = d; i_input_grant = g;
    if (r) begin
      q.delete();
      m_act = 0; m_rt = '0; m_err = 0; m_cnt = 0;
    end else if (c) begin
      full = q.size() >= DEPTH;
      popq = 0;
      if (!m_act && q.size() > 0) begin
        if (q[0][W-1]) begin
          m_rt = xy_route(q[0]);
          m_act = 1;
        end else begin
          popq = 1;
          m_err = 1;
        end
      end else if (g && m_req() != 0) begin
        popq = 1;
        if (q[0][W-2]) m_act = 0;
      end
      if (v && full) m_err = 1;
      if (popq) begin
        void'(q.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (v && !full) q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    reset = 1; ce = 1; i_valid = 0; i_data = '0; i_input_grant = 0;
    @(negedge clk);
    cyc(1, 1, 0, '0, 0);
    check("rst_en", 32'(o_en), 32'd1);
    check("rst_req", 32'(o_output_req), 32'd0);
    check("rst_err", 32'(o_error), 32'd0);
    cyc(0, 1, 1, flit(1, 1, 3, 1), 0);
    check("sf_req_t1", 32'(o_output_req), 32'd0);
    cyc(0, 1, 0, '0, 0);
    check("sf_req_t2", 32'(o_output_req), 32'b00100);
    cyc(0, 1, 0, '0, 1);
    check("sf_req_after", 32'(o_output_req), 32'd0);
    check("sf_en_after", 32'(o_en), 32'd1);
    cyc(1, 1, 0, '0, 0);
    cyc(0, 1, 1, flit(1, 0, 1, 1), 1);
    check("pkt_c1", 32'(o_output_req), 32'd0);
    cyc(0, 1, 1, flit(0, 0, 7, 7), 1);
    check("pkt_c2", 32'(o_output_req), 32'b00001);
    cyc(0, 1, 1, flit(0, 1, 5, 5), 1);
    check("pkt_c3", 32'(o_output_req), 32'b00001);
    cyc(0, 1, 0, '0, 1);
    check("pkt_c4", 32'(o_output_req), 32'b00001);
    cyc(0, 1, 0, '0, 1);
    check("pkt_c5", 32'(o_output_req), 32'd0);
    cyc(1, 1, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, flit(1, 0, 1, 0), 0);
    check("full_en", 32'(o_en), 32'd0);
    check("full_err0", 32'(o_error), 32'd0);
    cyc(0, 1, 1, flit(1, 0, 2, 2), 0);
    check("drop_err", 32'(o_error), 32'd1);
    check("drop_en", 32'(o_en), 32'd0);
    cyc(0, 1, 0, '0, 1);
    check("pop_en", 32'(o_en), 32'd1);
    cyc(1, 1, 0, '0, 0);
    cyc(0, 1, 1, flit(0, 0, 2, 2), 0);
    cyc(0, 1, 0, '0, 0);
    check("body_err", 32'(o_error), 32'd1);
    check("body_req", 32'(o_output_req), 32'd0);
    check("body_en", 32'(o_en), 32'd1);
    cyc(1, 1, 0, '0, 0);
    cyc(0, 1, 1, flit(1, 0, 0, 1), 0);
    cyc(0, 1, 1, flit(0, 0, 0, 1), 0);
    cyc(0, 1, 1, flit(0, 0, 0, 1), 0);
    check("mid_req", 32'(o_output_req), 32'b10000);
    cyc(1, 0, 0, '0, 0);
    check("mid_rst_en", 32'(o_en), 32'd1);
    check("mid_rst_req", 32'(o_output_req), 32'd0);
    check("mid_rst_err", 32'(o_error), 32'd0);
    cyc(0, 1, 1, flit(1, 1, 1, 2), 0);
    cyc(0, 0, 1, flit(0, 0, 0, 0), 1);
    cyc(0, 0, 1, flit(0, 0, 0, 0), 1);
    check("ce0_req", 32'(o_output_req), 32'd0);
    check("ce0_en", 32'(o_en), 32'd1);
    cyc(0, 1, 0, '0, 0);
    check("ce1_req", 32'(o_output_req), 32'b00010);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
          flit($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3)),
          $urandom_range(0, 1) == 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
